keypad_scan_ctrl: RTL and testbench

- Sequencing controller for the 4x4 keypad matrix.
- Drives one-hot active-high column strobes, synchronizes the asynchronous row inputs and debounces both press and release.
- Emits one registered key-code strobe per physical press.
- Sits between the keypad pins and the display/digit-history logic of keyscan; replaces ad-hoc column rotation with an explicit FSM.

---
 rtl/keyscan_pkg.sv | 11 +
 rtl/sync_2ff.sv | 21 ++
 rtl/keypad_scan_ctrl.sv | 75 +++++++
 tb/tb_keypad_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keyscan_pkg.sv
// keyscan_pkg: shared FSM states, column reset pattern and key-code helpers for the keypad scanner
package keyscan_pkg;
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;
  localparam logic [3:0] COL_RESET = 4'b0001;
  function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction
  function automatic logic [1:0] lowest_bit_idx(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta, r_sync;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end
  assign o_q = r_sync;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with press/release debounce and one key-code strobe per press
module keypad_scan_ctrl
  import keyscan_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r,
  output logic [3:0] c,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       pressed
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  state_t        r_state, w_state_nxt;
  logic [3:0]    w_rs, r_c, w_c_nxt, r_key;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_row, r_col;
  logic          r_valid, w_bit, w_dwell_end, w_cnt_end, w_capture, w_accept, w_advance;
  sync_2ff #(.W(4)) u_sync (.clk(clk), .reset(reset), .i_d(r), .o_q(w_rs));
  assign w_bit       = w_rs[r_row];
  assign w_dwell_end = r_dwell == DWELL_LAST;
  assign w_cnt_end   = r_cnt == CNT_LAST;
  assign w_capture   = (r_state == SCAN) && w_dwell_end && (|w_rs);
  assign w_accept    = (r_state == DEB_PRESS) && w_bit && w_cnt_end;
  // column moves on after an empty sample, a rejected bounce, or a completed release
  assign w_advance   = ((r_state == SCAN) && w_dwell_end && !(|w_rs)) ||
                       ((r_state == DEB_PRESS) && !w_bit) ||
                       ((r_state == DEB_REL) && !w_bit && w_cnt_end);
  assign w_c_nxt     = w_advance ? {r_c[2:0], r_c[3]} : r_c;
  assign w_dwell_nxt = ((r_state == SCAN) && !w_dwell_end) ? r_dwell + 1'b1 : '0;
  assign w_cnt_nxt   = (((r_state == DEB_PRESS) && w_bit) || ((r_state == DEB_REL) && !w_bit)) ? r_cnt + 1'b1 : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SCAN;
      r_c     <= COL_RESET;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_key   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_dwell <= w_dwell_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_capture ? lowest_bit_idx(w_rs) : r_row;
      r_col   <= w_capture ? lowest_bit_idx(r_c) : r_col;
      r_key   <= w_accept ? key_code(r_row, r_col) : r_key;
      r_valid <= w_accept;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN:      w_state_nxt = w_capture ? DEB_PRESS : SCAN;
      DEB_PRESS: w_state_nxt = !w_bit ? SCAN : w_cnt_end ? HELD : DEB_PRESS;
      HELD:      w_state_nxt = w_bit ? HELD : DEB_REL;
      default:   w_state_nxt = w_bit ? HELD : w_cnt_end ? SCAN : DEB_REL;
    endcase
  end
  always_comb begin
    c         = r_c;
    key       = r_key;
    key_valid = r_valid;
    pressed   = (r_state == HELD) || (r_state == DEB_REL);
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad scanner bench with a sample-history reference model and directed plus random key stimulus
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  logic clk, reset;
  logic [3:0] r, c, key;
  logic key_valid, pressed;
  logic [3:0] cdes, rdes;
  int n_chk, n_fail;
  logic chk_en, prev_valid;
  logic [3:0] m_c, m_key, h1, h2;
  logic m_valid, m_pressed, m_rst;
  logic [3:0] dut_keys[$];

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .r(r), .c(c), .key(key), .key_valid(key_valid), .pressed(pressed));

  // the keypad only connects row pins to the driven column
  assign r = (c == cdes) ? rdes : 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // one clock edge of the reference: rows seen by the scanner are the pin values from two edges earlier
  task automatic step(output logic [3:0] rs);
    logic [3:0] rn;
    @(posedge clk);
    m_valid = 1'b0;
    if (reset) begin
      h1 = 0; h2 = 0; m_c = 4'b0001; m_key = 0; m_pressed = 0; m_rst = 1; rs = 0;
      return;
    end
    rn = (m_c == cdes) ? rdes : 4'h0;
    rs = h2;
    h2 = h1;
    h1 = rn;
  endtask

  task automatic run_once();
    logic [3:0] rs;
    int row, col, n;
    forever begin
      for (int d = 0; d < SCAN_DIV; d++) begin
        step(rs);
        if (m_rst) return;
      end
      if (rs == 0) begin
        m_c = {m_c[2:0], m_c[3]};
        continue;
      end
      row = first_set(rs);
      col = first_set(m_c);
      n = 0;
      while (n < DEBOUNCE) begin
        step(rs);
        if (m_rst) return;
        if (!rs[row]) break;
        n++;
      end
      if (n < DEBOUNCE) begin
        m_c = {m_c[2:0], m_c[3]};
        continue;
      end
      m_key = 4'(row * 4 + col);
      m_valid = 1'b1;
      m_pressed = 1'b1;
      n = 0;
      while (n <= DEBOUNCE) begin
        step(rs);
        if (m_rst) return;
        n = rs[row] ? 0 : n + 1;
      end
      m_pressed = 1'b0;
      m_c = {m_c[2:0], m_c[3]};
    end
  endtask

  initial begin
    m_c = 4'b0001; m_key = 0; m_valid = 0; m_pressed = 0; h1 = 0; h2 = 0;
    forever begin
      m_rst = 0;
      run_once();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("c", c, m_c);
      chk("key", key, m_key);
      chk("key_valid", key_valid, m_valid);
      chk("pressed", pressed, m_pressed);
      chk("no_double_pulse", key_valid & prev_valid, 0);
      if (key_valid) dut_keys.push_back(key);
      prev_valid = key_valid;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    rdes = 0;
    @(negedge clk);
    reset = 1'b0;
    dut_keys.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 0; prev_valid = 0;
    reset = 1'b1; cdes = 0; rdes = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_c", c, 4'b0001);
    chk("reset_key", key, 0);
    chk("reset_pressed", pressed, 0);
    // idle rotation
    for (int k = 0; k < 40; k++) begin
      chk("idle_c", c, 32'(1 << ((k / 4) % 4)));
      @(negedge clk);
    end
    chk("idle_pulses", dut_keys.size(), 0);
    // key 7: row 1, column 3
    cdes = 4'b1000; rdes = 4'b0010;
    repeat (100) @(negedge clk);
    chk("k7_pulses", dut_keys.size(), 1);
    chk("k7_key", (dut_keys.size() == 1) ? 32'(dut_keys[0]) : 32'hFFFF, 7);
    chk("k7_c_frozen", c, 4'b1000);
    chk("k7_pressed", pressed, 1);
    rdes = 0;
    repeat (10) @(negedge clk);
    chk("k7_still_pressed", pressed, 1);
    @(negedge clk);
    chk("k7_released", pressed, 0);
    chk("k7_next_col", c, 4'b0001);
    // bounce on column 0 row 2
    do_reset();
    cdes = 4'b0001; rdes = 4'b0100;
    repeat (3) @(negedge clk);
    rdes = 0;
    repeat (3) @(negedge clk);
    chk("bounce_c", c, 4'b0010);
    chk("bounce_pressed", pressed, 0);
    chk("bounce_pulses", dut_keys.size(), 0);
    // key A with a release glitch
    cdes = 4'b0100; rdes = 4'b0100;
    repeat (100) @(negedge clk);
    chk("kA_pulses", dut_keys.size(), 1);
    chk("kA_key", (dut_keys.size() == 1) ? 32'(dut_keys[0]) : 32'hFFFF, 4'hA);
    rdes = 0;
    repeat (3) @(negedge clk);
    rdes = 4'b0100;
    repeat (40) @(negedge clk);
    chk("kA_glitch_pressed", pressed, 1);
    chk("kA_glitch_pulses", dut_keys.size(), 1);
    rdes = 0;
    repeat (30) @(negedge clk);
    chk("kA_release", pressed, 0);
    chk("kA_final_pulses", dut_keys.size(), 1);
    // rows 0 and 3 together in column 2, then reset while held
    dut_keys.delete();
    cdes = 4'b0100; rdes = 4'b1001;
    repeat (100) @(negedge clk);
    chk("multi_pulses", dut_keys.size(), 1);
    chk("multi_key", (dut_keys.size() == 1) ? 32'(dut_keys[0]) : 32'hFFFF, 2);
    chk("multi_pressed", pressed, 1);
    reset = 1'b1; rdes = 0;
    @(negedge clk);
    chk("held_reset_c", c, 4'b0001);
    chk("held_reset_pressed", pressed, 0);
    chk("held_reset_key", key, 0);
    chk("held_reset_valid", key_valid, 0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("held_reset_pulses", dut_keys.size(), 1);
    // sweep of all 16 keys
    dut_keys.delete();
    for (int k = 0; k < 16; k++) begin
      cdes = 4'(1 << (k % 4));
      rdes = 4'(1 << (k / 4));
      repeat (100) @(negedge clk);
      rdes = 0;
      repeat (100) @(negedge clk);
    end
    chk("sweep_count", dut_keys.size(), 16);
    for (int i = 0; i < 16; i++)
      chk("sweep_key", (i < dut_keys.size()) ? 32'(dut_keys[i]) : 32'hFF, i);
    // random keys, chords and occasional resets
    repeat (120) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        rdes = 0;
        @(negedge clk);
        reset = 1'b0;
      end
      cdes = 4'(1 << $urandom_range(0, 3));
      rdes = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
